spdif_lock_ctrl: RTL and testbench
==================================

SPDIF_LOCK_CTRL -- requirements
Module: spdif_lock_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the interval counter and of ui_len.
REQ-002 Parameter: LOCK_PRE, default 8, number of consecutive error-free preambles required to lock.
REQ-003 Parameter: LOSS_MAX, default 4, number of accumulated errors that forces loss of lock.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: resetb  input  1  reset, synchronous, active-low.
REQ-006 Port: edge_in  input  1  one-cycle pulse marking a line transition, from the front-end edge detector.
REQ-007 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-008 Port: ui_len  output  CNT_W  estimated unit interval, in clk cycles.
REQ-009 Port: pre_stb  output  1  one-cycle pulse when a preamble is fully classified.
REQ-010 Port: pre_type  output  2  preamble class, valid with pre_stb: 0=B, 1=M, 2=W; 3 is never driven.
REQ-011 Port: err_stb  output  1  one-cycle pulse on an unclassifiable interval.

Function
REQ-012 The interval counter shall increment by 1 each cycle and saturate at 2^CNT_W-1.
REQ-013 On edge_in, len shall be the counter value in that cycle, and the counter shall load 1.
REQ-014 Glitch rule: len < 2 shall be ignored, with no classification and no edge count.
REQ-015 Classification with U=ui_len: C1 if len <= U+U/2; C2 if len <= 2U+U/2; C3 if len <= 3U+U/2; otherwise CE. All arithmetic is CNT_W+2 bits wide.
REQ-016 FSM states: SEARCH, TRAIN, LOCKED.
REQ-017 SEARCH: min_len starts at all-ones and tracks the minimum non-glitch len over 64 edges.
REQ-018 After the 64th edge in SEARCH, the FSM shall load ui_len=min_len and go to TRAIN; if min_len < 2, it shall restart SEARCH instead.
REQ-019 A preamble starts on a C3 that is not itself the second pulse of an M.
REQ-020 The next pulse after the start shall decide the class: C1 -> B, C3 -> M, C2 -> W.
REQ-021 pre_stb shall pulse in the cycle after that second edge.
REQ-022 TRAIN: each preamble increments good_cnt.
REQ-023 TRAIN: good_cnt reaching LOCK_PRE -> LOCKED, with locked set in the next cycle.
REQ-024 TRAIN: any CE -> SEARCH and good_cnt=0.
REQ-025 LOCKED: each CE increments err_cnt.
REQ-026 LOCKED: a preamble clears err_cnt, unless a CE occurs in the same edge.
REQ-027 LOCKED: err_cnt reaching LOSS_MAX -> SEARCH and locked=0 next cycle.
REQ-028 Timeout: in TRAIN or LOCKED, counter saturation -> SEARCH with err_stb pulsed once.
REQ-029 err_stb shall pulse for every CE in any state, and for timeout.
REQ-030 Entering SEARCH shall clear good_cnt, err_cnt and min_len, and shall hold ui_len at its last value.
REQ-031 Simultaneous CE and timeout shall produce a single err_stb pulse.

Reset
REQ-032 On resetb=0: state=SEARCH, counter=1, ui_len=0, min_len=all-ones, good_cnt=0, err_cnt=0.
REQ-033 On resetb=0: locked, pre_stb, err_stb and pre_type shall all be 0.
REQ-034 Reset asserted mid-preamble shall discard the partial classification; no pre_stb after release.

Configuration
REQ-035 Macro SPDIF_LOCK_STATS_EN defined: the block shall add output port loss_cnt (16 bits), counting LOCKED->SEARCH transitions, saturating at 65535, and reset to 0.
REQ-036 Macro SPDIF_LOCK_STATS_EN undefined: port loss_cnt and its logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-037 64 edges at spacing 4, then B/M/W frames with U=4 -> ui_len=4; TRAIN; locked=1 after the 8th preamble.
REQ-038 Locked, with pulses 12,4 / 12,12 / 12,8 -> pre_type 0 / 1 / 2, each with exactly one pre_stb.
REQ-039 Locked, 4 intervals of length 20 with no preamble between them (U=4) -> 4 err_stb pulses, then locked=0.
REQ-040 Locked, edge_in stopped for 300 cycles -> a single err_stb at saturation, then SEARCH with ui_len still 4.
REQ-041 A 1-cycle glitch interleaved into a U=4 stream -> ignored; ui_len not 1; lock unaffected.
REQ-042 resetb low 1 cycle between 12 and 4 pulses -> no pre_stb; all outputs 0; loss_cnt=0 with SPDIF_LOCK_STATS_EN.

Source files
------------

// File: rtl/spdif_lock_ctrl.sv
// S/PDIF lock controller: interval classifier, preamble detector and lock FSM.
// Optional loss statistics: define SPDIF_LOCK_STATS_EN to add loss_cnt.
module spdif_lock_ctrl #(
    parameter int CNT_W    = 8,
    parameter int LOCK_PRE = 8,
    parameter int LOSS_MAX = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             edge_in,
    output logic             locked,
    output logic [CNT_W-1:0] ui_len,
    output logic             pre_stb,
    output logic [1:0]       pre_type,
    output logic             err_stb
`ifdef SPDIF_LOCK_STATS_EN
    ,
    output logic [15:0]      loss_cnt
`endif
);

    localparam int XW = CNT_W + 2;
    localparam int GW = $clog2(LOCK_PRE + 1);
    localparam int EW = $clog2(LOSS_MAX + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        C1,
        C2,
        C3,
        CE
    } cls_t;

    state_t           state, state_n;
    cls_t             cls;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] min_len, min_n, min_new, ui_n;
    logic [5:0]       ecnt, ecnt_n;
    logic [GW-1:0]    good_cnt, good_n, good_inc;
    logic [EW-1:0]    err_cnt, err_n, err_inc;
    logic             pend, pend_n;
    logic             pre_stb_n, err_stb_n;
    logic [1:0]       pre_type_n;
    logic             valid, timeout, pre_hit;
    logic [XW-1:0]    u_x, h_x, len_x, t1, t2, t3;

    assign valid    = edge_in && (cnt >= CNT_W'(2));
    assign timeout  = (state != SEARCH) && (cnt == CMAX);
    assign good_inc = good_cnt + GW'(1);
    assign err_inc  = err_cnt + EW'(1);
    assign locked   = (state == LOCKED);

    // Interval counter: restarts on every edge, sticks at full scale.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt <= CNT_W'(1);
        end else if (edge_in) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CMAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Classify the interval ending now against 1.5U, 2.5U and 3.5U.
    always_comb begin
        u_x   = {2'b00, ui_len};
        h_x   = u_x >> 1;
        t1    = u_x + h_x;
        t2    = t1 + u_x;
        t3    = t2 + u_x;
        len_x = {2'b00, cnt};
        if (len_x <= t1) begin
            cls = C1;
        end else if (len_x <= t2) begin
            cls = C2;
        end else if (len_x <= t3) begin
            cls = C3;
        end else begin
            cls = CE;
        end
    end

    // Next-state logic for the lock FSM, preamble tracker and strobes.
    always_comb begin
        state_n    = state;
        ui_n       = ui_len;
        min_n      = min_len;
        ecnt_n     = ecnt;
        good_n     = good_cnt;
        err_n      = err_cnt;
        pend_n     = pend;
        pre_stb_n  = 1'b0;
        pre_type_n = pre_type;
        err_stb_n  = 1'b0;
        min_new    = (cnt < min_len) ? cnt : min_len;
        pre_hit    = valid && pend && (cls != CE);

        if (valid) begin
            // The second pulse of an M is a C3 but never opens a new preamble.
            pend_n    = !pend && (cls == C3);
            err_stb_n = (cls == CE);
        end

        if (pre_hit) begin
            pre_stb_n = 1'b1;
            unique case (cls)
                C1:      pre_type_n = 2'd0;
                C3:      pre_type_n = 2'd1;
                C2:      pre_type_n = 2'd2;
                default: pre_type_n = pre_type;
            endcase
        end

        if (timeout) begin
            state_n   = SEARCH;
            err_stb_n = 1'b1;
        end else begin
            unique case (state)
                SEARCH: begin
                    if (valid) begin
                        if (ecnt == 6'd63) begin
                            ecnt_n = '0;
                            min_n  = '1;
                            if (min_new >= CNT_W'(2)) begin
                                ui_n    = min_new;
                                state_n = TRAIN;
                                good_n  = '0;
                            end
                        end else begin
                            ecnt_n = ecnt + 6'd1;
                            min_n  = min_new;
                        end
                    end
                end
                TRAIN: begin
                    if (valid && (cls == CE)) begin
                        state_n = SEARCH;
                    end else if (pre_hit) begin
                        if (good_inc == GW'(LOCK_PRE)) begin
                            state_n = LOCKED;
                        end else begin
                            good_n = good_inc;
                        end
                    end
                end
                LOCKED: begin
                    if (valid && (cls == CE)) begin
                        if (err_inc == EW'(LOSS_MAX)) begin
                            state_n = SEARCH;
                        end else begin
                            err_n = err_inc;
                        end
                    end else if (pre_hit) begin
                        err_n = '0;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        // Fresh search statistics on every re-entry; ui_len is kept.
        if ((state_n == SEARCH) && (state != SEARCH)) begin
            good_n = '0;
            err_n  = '0;
            min_n  = '1;
            ecnt_n = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= SEARCH;
            ui_len   <= '0;
            min_len  <= '1;
            ecnt     <= '0;
            good_cnt <= '0;
            err_cnt  <= '0;
            pend     <= 1'b0;
            pre_stb  <= 1'b0;
            pre_type <= 2'd0;
            err_stb  <= 1'b0;
        end else begin
            state    <= state_n;
            ui_len   <= ui_n;
            min_len  <= min_n;
            ecnt     <= ecnt_n;
            good_cnt <= good_n;
            err_cnt  <= err_n;
            pend     <= pend_n;
            pre_stb  <= pre_stb_n;
            pre_type <= pre_type_n;
            err_stb  <= err_stb_n;
        end
    end

`ifdef SPDIF_LOCK_STATS_EN
    // Count lock losses, saturating.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            loss_cnt <= '0;
        end else if ((state == LOCKED) && (state_n == SEARCH) &&
                     (loss_cnt != 16'hFFFF)) begin
            loss_cnt <= loss_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Randomized bench for spdif_lock_ctrl against an interval-level model.
// Define SPDIF_LOCK_STATS_EN to also check loss_cnt.
module tb_spdif_lock_ctrl;

    localparam int CNT_W    = 8;
    localparam int LOCK_PRE = 8;
    localparam int LOSS_MAX = 4;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic             clk;
    logic             resetb;
    logic             edge_in;
    logic             locked;
    logic [CNT_W-1:0] ui_len;
    logic             pre_stb;
    logic [1:0]       pre_type;
    logic             err_stb;
`ifdef SPDIF_LOCK_STATS_EN
    logic [15:0]      loss_cnt;
`endif

    spdif_lock_ctrl #(
        .CNT_W   (CNT_W),
        .LOCK_PRE(LOCK_PRE),
        .LOSS_MAX(LOSS_MAX)
    ) dut (
        .clk     (clk),
        .resetb  (resetb),
        .edge_in (edge_in),
        .locked  (locked),
        .ui_len  (ui_len),
        .pre_stb (pre_stb),
        .pre_type(pre_type),
        .err_stb (err_stb)
`ifdef SPDIF_LOCK_STATS_EN
        ,
        .loss_cnt(loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int n_pre = 0;
    int n_err = 0;
    int last_type = -1;

    typedef enum int { M_SEARCH, M_TRAIN, M_LOCKED } mode_t;

    mode_t m_mode = M_SEARCH;
    int    since = 1;
    int    m_ui = 0, m_min = MAXV, m_edges = 0;
    int    m_good = 0, m_errs = 0, m_loss = 0;
    bit    m_pend = 0;
    int    x_pre = 0, x_type = 0, x_err = 0, x_lock = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Returns multiple of U the interval matches (1..3), 0 if none.
    function automatic int klass(input int len, input int u);
        for (int k = 1; k <= 3; k++) begin
            if (len <= k * u + u / 2) return k;
        end
        return 0;
    endfunction

    task automatic mdl_step(input bit e, input bit rb);
        mode_t prev;
        int    len, k;
        bit    hit, ce, tmo, ok;
        if (!rb) begin
            m_mode = M_SEARCH; since = 1; m_ui = 0; m_min = MAXV;
            m_edges = 0; m_good = 0; m_errs = 0; m_pend = 0;
            m_loss = 0; x_pre = 0; x_type = 0; x_err = 0; x_lock = 0;
            return;
        end
        x_pre = 0; x_err = 0; prev = m_mode;
        tmo = (m_mode != M_SEARCH) && (since == MAXV);
        ok = e && (since >= 2);
        hit = 0; ce = 0; len = since; k = 0;
        if (ok) begin
            k = klass(len, m_ui);
            ce = (k == 0);
            if (m_pend) begin
                m_pend = 0;
                if (!ce) begin
                    hit = 1; x_pre = 1;
                    x_type = (k == 1) ? 0 : (k == 3) ? 1 : 2;
                end
            end else begin
                m_pend = (k == 3);
            end
            if (ce) x_err = 1;
        end
        if (tmo) begin
            x_err = 1; m_mode = M_SEARCH;
        end else begin
            case (m_mode)
                M_SEARCH: if (ok) begin
                    m_edges++;
                    if (len < m_min) m_min = len;
                    if (m_edges == 64) begin
                        if (m_min >= 2) begin
                            m_ui = m_min; m_mode = M_TRAIN; m_good = 0;
                        end
                        m_edges = 0; m_min = MAXV;
                    end
                end
                M_TRAIN: if (ce) m_mode = M_SEARCH;
                    else if (hit) begin
                        m_good++;
                        if (m_good == LOCK_PRE) m_mode = M_LOCKED;
                    end
                default: if (ce) begin
                        m_errs++;
                        if (m_errs == LOSS_MAX) m_mode = M_SEARCH;
                    end else if (hit) m_errs = 0;
            endcase
        end
        if (m_mode == M_SEARCH && prev != M_SEARCH) begin
            m_good = 0; m_errs = 0; m_min = MAXV; m_edges = 0;
            if (prev == M_LOCKED && m_loss < 65535) m_loss++;
        end
        since = e ? 1 : ((since < MAXV) ? since + 1 : MAXV);
        x_lock = (m_mode == M_LOCKED) ? 1 : 0;
    endtask

    task automatic cyc(input bit e, input bit rb);
        edge_in = e;
        resetb  = rb;
        @(posedge clk);
        mdl_step(e, rb);
        #1;
        chk("locked", locked, x_lock);
        chk("ui_len", ui_len, m_ui);
        chk("pre_stb", pre_stb, x_pre);
        chk("err_stb", err_stb, x_err);
        if (x_pre != 0 || !rb) chk("pre_type", pre_type, x_type);
`ifdef SPDIF_LOCK_STATS_EN
        chk("loss_cnt", loss_cnt, m_loss);
`endif
        if (pre_stb === 1'b1) begin
            n_pre++;
            last_type = int'(pre_type);
        end
        if (err_stb === 1'b1) n_err++;
    endtask

    task automatic pulse(input int l);
        repeat (l - 1) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
    endtask

    task automatic gpulse(input int l);
        if ($urandom_range(0, 3) == 0) begin
            pulse(1);
            pulse(l - 1);
        end else begin
            pulse(l);
        end
    endtask

    task automatic frame(input bit glitchy);
        int t, n, d;
        t = $urandom_range(0, 2);
        d = (t == 0) ? 4 : (t == 1) ? 12 : 8;
        if (glitchy) begin
            gpulse(12); gpulse(d);
        end else begin
            pulse(12); pulse(d);
        end
        n = $urandom_range(1, 4);
        repeat (n) begin
            d = ($urandom_range(0, 1) != 0) ? 4 : 8;
            if (glitchy) gpulse(d + $urandom_range(0, 2) - 1);
            else pulse(d);
        end
    endtask

    task automatic do_search(input bit glitchy);
        repeat (64) begin
            pulse(4);
            if (glitchy && $urandom_range(0, 3) == 0) pulse(1);
        end
    endtask

    task automatic do_lock();
        repeat (LOCK_PRE - 1) frame(1'b0);
        chk("not_locked_before_last", locked, 0);
        frame(1'b0);
        chk("locked_after_last", locked, 1);
    endtask

    initial begin
        int r, k;
        edge_in = 1'b0;
        resetb  = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_ui", ui_len, 0);
        chk("rst_pre_type", pre_type, 0);

        do_search(1'b0);
        chk("ui_after_search", ui_len, 4);
        do_lock();

        for (int t = 0; t < 3; t++) begin
            n_pre = 0;
            pulse(12);
            pulse((t == 0) ? 4 : (t == 1) ? 12 : 8);
            cyc(1'b0, 1'b1);
            chk("pre_count", n_pre, 1);
            chk("pre_class", last_type, t);
            pulse(4);
        end

        repeat (30) frame(1'b1);
        chk("locked_glitches", locked, 1);

        n_err = 0;
        repeat (3) pulse(20);
        chk("locked_3ce", locked, 1);
        pulse(20);
        chk("ce_count", n_err, 4);
        chk("unlocked_4ce", locked, 0);

        do_search(1'b0);
        do_lock();
        n_err = 0;
        repeat (300) cyc(1'b0, 1'b1);
        chk("timeout_err", n_err, 1);
        chk("timeout_unlock", locked, 0);
        chk("timeout_ui", ui_len, 4);

        do_search(1'b1);
        chk("ui_glitch_search", ui_len, 4);
        do_lock();
        pulse(12);
        n_pre = 0;
        cyc(1'b0, 1'b0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_pre", pre_stb, 0);
        chk("mid_rst_err", err_stb, 0);
        chk("mid_rst_ui", ui_len, 0);
`ifdef SPDIF_LOCK_STATS_EN
        chk("mid_rst_loss", loss_cnt, 0);
`endif
        pulse(4);
        repeat (4) cyc(1'b0, 1'b1);
        chk("mid_rst_no_pre", n_pre, 0);

        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                cyc(1'b0, 1'b0);
            end else if (r < 6) begin
                pulse(1);
            end else if (r < 14) begin
                pulse($urandom_range(15, 40));
            end else begin
                k = $urandom_range(1, 3);
                pulse(4 * k + $urandom_range(0, 2) - 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
